// File: rtl/dac_frame_driver_if.sv
// Shadow-sample write bus from the filter/processing datapath into the DAC frame driver.
// Writes are always accepted, so the bus carries no back-pressure.
interface dac_frame_driver_if #(
    parameter int CH_W   = 2,
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_ch, wr_data);
    modport slave  (input  wr_en, wr_ch, wr_data);
endinterface

// File: rtl/dac_frame_driver.sv
// Multi-channel serial DAC frame driver: per-channel shadow samples, round-robin scheduling,
// fixed-length frames of {0, address, sample, zero pad} with a programmable Sync window.
module dac_frame_driver #(
    parameter int   DATA_W     = 8,
    parameter int   NUM_CH     = 4,
    parameter int   CH_W       = 2,
    parameter int   FRAME_LEN  = 20,
    parameter int   SYNC_START = 16,
    parameter int   SYNC_STOP  = 19,
    parameter logic SYNC_POL   = 1'b1
) (
    input  logic              clk_DAC,
    input  logic              rst_n,
    dac_frame_driver_if.slave wr_if,
    input  logic              DAC_En_i,
    input  logic              mode_i,
    output logic              DAC_Din_o,
    output logic              DAC_Sync_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [CH_W-1:0]   cur_ch_o
);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int SH_W  = CH_W + DATA_W;
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_ON    = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_OFF   = CNT_W'(SYNC_STOP);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              din_q;
    logic              sync_q;
    logic              busy_q;
    logic              done_q;
    logic              active_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic [CH_W-1:0]   last_ch_q;
    logic [SH_W-1:0]   sh_q;
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [NUM_CH-1:0] dirty_q;

    logic              pick_found;
    logic [CH_W-1:0]   pick_ch;
    logic              frame_start;
    logic              load_en;
    logic              wr_ok;

    assign frame_start = (cnt_q == '0) && DAC_En_i;
    assign load_en     = frame_start && pick_found;
    assign wr_ok       = wr_if.wr_en && ({1'b0, wr_if.wr_ch} < (CH_W + 1)'(NUM_CH));
    assign cnt_d       = (cnt_q == LAST_SLOT) ? '0 : cnt_q + CNT_W'(1);

    // Walk offsets from farthest to nearest so the nearest eligible channel after last_ch wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_ch    = last_ch_q;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last_ch_q) + i) % NUM_CH;
            if (mode_i ? dirty_q[CH_W'(idx)] : (i == 1)) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(idx);
            end
        end
    end

    // A write landing on the channel being loaded wins over the dirty clear, keeping it pending.
    always_ff @(posedge clk_DAC or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            if (load_en) begin
                dirty_q[pick_ch] <= 1'b0;
            end
            if (wr_ok) begin
                shadow_q[wr_if.wr_ch] <= wr_if.wr_data;
                dirty_q[wr_if.wr_ch]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_DAC or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            din_q     <= 1'b0;
            sync_q    <= ~SYNC_POL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            active_q  <= 1'b0;
            cur_ch_q  <= '0;
            last_ch_q <= CH_W'(NUM_CH - 1);
            sh_q      <= '0;
        end else if ((cnt_q == '0) && !DAC_En_i) begin
            cnt_q    <= '0;
            din_q    <= 1'b0;
            sync_q   <= ~SYNC_POL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= 1'b1;
            done_q <= active_q && (cnt_q == LAST_SLOT);
            sync_q <= (active_q && (cnt_q >= SYNC_ON) && (cnt_q < SYNC_OFF)) ? SYNC_POL : ~SYNC_POL;
            if (frame_start) begin
                din_q    <= 1'b0;
                active_q <= pick_found;
                if (pick_found) begin
                    sh_q      <= {pick_ch, shadow_q[pick_ch]};
                    cur_ch_q  <= pick_ch;
                    last_ch_q <= pick_ch;
                end
            end else begin
                // Zeros shift in behind the payload, which supplies the trailing pad slots.
                din_q <= active_q & sh_q[SH_W-1];
                sh_q  <= sh_q << 1;
            end
        end
    end

    assign DAC_Din_o    = din_q;
    assign DAC_Sync_o   = sync_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign cur_ch_o     = cur_ch_q;
endmodule
